// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, M-extension divide op encodings
// and the divider FSM state type.
package rv32_pkg;

  localparam int XLEN = 32;

  // funct3[1:0] of DIV/DIVU/REM/REMU
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration. The partial remainder is shifted
// left by one, taking in the quotient MSB, and the divisor is trial-subtracted
// with an explicit ripple-borrow chain. The shifted remainder is XLEN+1 bits,
// so divisors with the top bit set are handled without losing the carried-out bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] q_out
);

  logic [XLEN:0]   part;
  logic [XLEN:0]   sub_b;
  logic [XLEN+1:0] borrow;
  logic [XLEN-1:0] diff;
  logic            restore;

  assign part      = {rem_in, q_in[XLEN-1]};
  assign sub_b     = {1'b0, dvs};
  assign borrow[0] = 1'b0;

  // Full-subtractor borrow chain across all XLEN+1 bits
  for (genvar gi = 0; gi <= XLEN; gi++) begin : g_borrow
    assign borrow[gi+1] = (~part[gi] & sub_b[gi]) | (~(part[gi] ^ sub_b[gi]) & borrow[gi]);
  end

  // Difference bits; the top one is always zero when the subtract is kept
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_diff
    assign diff[gi] = part[gi] ^ sub_b[gi] ^ borrow[gi];
  end

  // Final borrow means part < dvs: keep the shifted remainder, quotient bit 0
  assign restore = borrow[XLEN+1];
  assign rem_out = restore ? part[XLEN-1:0] : diff;
  assign q_out   = {q_in[XLEN-2:0], ~restore};

endmodule

// File: rtl/div_unit_rv32m.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU). Operands are reduced to
// magnitudes, divided one quotient bit per cycle, then sign-corrected.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module div_unit_rv32m #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import rv32_pkg::*;

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic            sel_rem;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_q;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .q_in    (quo),
    .dvs     (dvs),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Operand preconditioning and special-case detection for the issue cycle
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign abs_a     = a_neg ? (~dividend + 1'b1) : dividend;
  assign abs_b     = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed & (dividend == MIN_NEG) & (divisor == '1);

  // Sign correction of the finished magnitudes
  assign q_fix = neg_q ? (~quo + 1'b1) : quo;
  assign r_fix = neg_r ? (~rem + 1'b1) : rem;

  // Divider control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      // Abort: result keeps the last completed value
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sel_rem <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            cnt     <= '0;
            busy    <= 1'b1;
            if (div_zero) begin
              result <= op[1] ? dividend : '1;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else if (overflow) begin
              result <= op[1] ? '0 : MIN_NEG;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              rem   <= '0;
              quo   <= abs_a;
              dvs   <= abs_b;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem <= step_rem;
          quo <= step_q;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result <= sel_rem ? r_fix : q_fix;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_rv32m.sv
// Bench for div_unit_rv32m: directed vector table, multi-cycle corner
// sequences (flush, start-while-busy, back-to-back, async reset) and
// randomized operations against a plain-arithmetic reference model.
module tb_div_unit_rv32m;

  localparam int W = 32;
  localparam int NVEC = 12;
  localparam int NRAND = 1000;
  localparam int LAT_NORMAL = W + 2;
  localparam int LAT_LIMIT = 100;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [NVEC];

  div_unit_rv32m dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V division semantics straight from the ISA rules
  function automatic logic [W-1:0] model(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return m_op[1] ? a : '1;
    if (!m_op[0]) begin
      if (a == MINV && b == '1) return m_op[1] ? '0 : MINV;
      return m_op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    end
    return m_op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 1;
    if (!m_op[0] && a == MINV && b == '1) return 1;
    return LAT_NORMAL;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Count cycles after the accept cycle until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Issue one op from IDLE, wait for done, return to IDLE
  task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    op = t_op;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    res = result;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] prev;
    int lat;
    int pulses;

    vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        LAT_NORMAL};
    vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         LAT_NORMAL};
    vecs[2]  = '{2'b00, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, LAT_NORMAL};
    vecs[3]  = '{2'b10, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, LAT_NORMAL};
    vecs[4]  = '{2'b10, 32'd20,        32'hFFFF_FFFD, 32'd2,         LAT_NORMAL};
    vecs[5]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         LAT_NORMAL};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         LAT_NORMAL};
    vecs[11] = '{2'b01, 32'd1000,      32'd3,         32'd333,       LAT_NORMAL};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      $display("vec %0d op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
    end
    prev = vecs[NVEC-1].exp;

    // Flush in the 10th cycle of DIVU 1000/3
    op = 2'b01;
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("flush_busy_before", W'(busy), 1);
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", W'(busy), 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    $display("flush seq: done_pulses=%0d result=0x%08h", pulses, result);
    check("flush_no_done", W'(pulses), 0);
    check("flush_result_kept", result, prev);

    // Flush and start together: request dropped
    op = 2'b01;
    dividend = 32'd9;
    divisor = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    $display("flush+start: busy=%0d", busy);
    check("flush_start_busy", W'(busy), 0);
    @(posedge clk);
    #1;

    // Start held while busy with changing operands, then back-to-back accept
    op = 2'b01;
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'd50;
    divisor = 32'd5;
    wait_done(lat);
    $display("held start: result=0x%08h lat=%0d", result, lat);
    check("held_result", result, 32'd14);
    check("held_latency", W'(lat), W'(LAT_NORMAL));
    @(posedge clk);
    #1;
    check("b2b_idle_gap", W'(busy), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accepted", W'(busy), 1);
    wait_done(lat);
    $display("back-to-back: result=0x%08h lat=%0d", result, lat);
    check("b2b_result", result, 32'd10);
    check("b2b_latency", W'(lat), W'(LAT_NORMAL));
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of an operation
    op = 2'b01;
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0d done=%0d result=0x%08h", busy, done, result);
    check("arst_busy", W'(busy), 0);
    check("arst_done", W'(done), 0);
    check("arst_result", result, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized operations against the reference model
    for (int n = 0; n < NRAND; n++) begin
      logic [1:0]   r_op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      r_op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        3: b = $urandom | MINV;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = MINV;
      if ($urandom_range(0, 9) == 0) a = W'($urandom_range(0, 20));
      run_op(r_op, a, b, res, lat);
      $display("rand %0d op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d", n, r_op, a, b, res, lat);
      check("rand_result", res, model(r_op, a, b));
      check("rand_latency", W'(lat), W'(model_lat(r_op, a, b)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
